// File: rtl/fetch_unit_if.sv
// Bundle of the ROM port plus the fetch-to-decode handshake.
// The master modport is the fetch unit's view; the slave modport is the surrounding pipeline/ROM.
interface fetch_unit_if #(
  parameter int unsigned PC_WIDTH    = 16,
  parameter int unsigned INSTR_WIDTH = 20
);
  logic                   stall;
  logic                   branch_taken;
  logic [PC_WIDTH-1:0]    branch_address;
  logic [PC_WIDTH-1:0]    imem_addr;
  logic                   imem_rd_en;
  logic [INSTR_WIDTH-1:0] imem_rdata;
  logic [INSTR_WIDTH-1:0] instruction_fetch;
  logic [PC_WIDTH-1:0]    pc_mux_output;
  logic                   fetch_valid;
  logic                   halted;
  logic [15:0]            fetch_count;

  modport master (
    input  stall, branch_taken, branch_address, imem_rdata,
    output imem_addr, imem_rd_en, instruction_fetch, pc_mux_output,
           fetch_valid, halted, fetch_count
  );

  modport slave (
    output stall, branch_taken, branch_address, imem_rdata,
    input  imem_addr, imem_rd_en, instruction_fetch, pc_mux_output,
           fetch_valid, halted, fetch_count
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: sequences the PC into a 1-cycle synchronous ROM,
// holds on stall, redirects on taken branch and stops on a HALT opcode.
module fetch_unit #(
  parameter int unsigned         PC_WIDTH    = 16,
  parameter int unsigned         INSTR_WIDTH = 20,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = 16'h0000,
  parameter logic [4:0]          HALT_OPCODE = 5'b11111
) (
  input logic          clk,
  input logic          reset,
  fetch_unit_if.master bus
);

  localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_BOOT   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [PC_WIDTH-1:0] r_issue_pc;
  logic [PC_WIDTH-1:0] r_out_pc;
  logic                r_out_valid;
  logic [15:0]         r_fetch_count;
  logic [PC_WIDTH-1:0] w_issue_pc_next;
  logic [PC_WIDTH-1:0] w_out_pc_next;
  logic                w_out_valid_next;
  logic                w_halt_word;
  logic                w_accept;

  assign w_halt_word = r_out_valid && (bus.imem_rdata[INSTR_WIDTH-1 -: 5] == HALT_OPCODE);
  assign w_accept    = r_out_valid && !bus.stall;

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_BOOT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state: branch and stall both keep RUN and mask HALT detection
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_BOOT:   w_state_next = S_RUN;
      S_RUN: begin
        if (!bus.branch_taken && !bus.stall && w_halt_word) begin
          w_state_next = S_HALTED;
        end else begin
          w_state_next = S_RUN;
        end
      end
      S_HALTED: w_state_next = S_HALTED;
      default:  w_state_next = S_BOOT;
    endcase
  end

  // PC / valid next values for each state
  always_comb begin
    w_out_pc_next    = r_out_pc;
    w_issue_pc_next  = r_issue_pc;
    w_out_valid_next = r_out_valid;
    case (r_state)
      S_BOOT: begin
        w_out_pc_next    = RESET_PC;
        w_issue_pc_next  = RESET_PC + PC_ONE;
        w_out_valid_next = 1'b1;
      end
      S_RUN: begin
        if (bus.branch_taken) begin
          w_out_pc_next    = bus.branch_address;
          w_issue_pc_next  = bus.branch_address + PC_ONE;
          w_out_valid_next = 1'b1;
        end else if (bus.stall) begin
          w_out_pc_next    = r_out_pc;
          w_issue_pc_next  = r_issue_pc;
          w_out_valid_next = r_out_valid;
        end else if (w_halt_word) begin
          w_out_valid_next = 1'b0;
        end else begin
          w_out_pc_next    = r_issue_pc;
          w_issue_pc_next  = r_issue_pc + PC_ONE;
          w_out_valid_next = 1'b1;
        end
      end
      S_HALTED: w_out_valid_next = 1'b0;
      default:  w_out_valid_next = 1'b0;
    endcase
  end

  // PC and valid registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_issue_pc  <= RESET_PC;
      r_out_pc    <= RESET_PC;
      r_out_valid <= 1'b0;
    end else begin
      r_issue_pc  <= w_issue_pc_next;
      r_out_pc    <= w_out_pc_next;
      r_out_valid <= w_out_valid_next;
    end
  end

  // Saturating count of words accepted by decode (wrong-path and HALT words included)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fetch_count <= 16'h0000;
    end else if (w_accept && (r_fetch_count != 16'hFFFF)) begin
      r_fetch_count <= r_fetch_count + 16'h0001;
    end else begin
      r_fetch_count <= r_fetch_count;
    end
  end

  // Outputs; the stall re-read keeps imem_rdata stable for the held word
  always_comb begin
    bus.imem_addr = r_issue_pc;
    if ((r_state == S_RUN) && bus.branch_taken) begin
      bus.imem_addr = bus.branch_address;
    end else if (bus.stall && r_out_valid) begin
      bus.imem_addr = r_out_pc;
    end else begin
      bus.imem_addr = r_issue_pc;
    end
    bus.imem_rd_en        = (r_state != S_HALTED);
    bus.instruction_fetch = r_out_valid ? bus.imem_rdata : {INSTR_WIDTH{1'b0}};
    bus.pc_mux_output     = r_out_pc;
    bus.fetch_valid       = r_out_valid;
    bus.halted            = (r_state == S_HALTED);
    bus.fetch_count       = r_fetch_count;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a transaction-level fetch model pushes the expected
// per-cycle view, a negedge monitor pops and compares; a second instance covers PC wrap.
module tb_fetch_unit;
  localparam int unsigned PW = 16;
  localparam int unsigned IW = 20;
  localparam logic [4:0]  HALT_OP = 5'b11111;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fetch_unit_if #(.PC_WIDTH(PW), .INSTR_WIDTH(IW)) bus0 ();
  fetch_unit_if #(.PC_WIDTH(PW), .INSTR_WIDTH(IW)) bus1 ();

  fetch_unit #(.PC_WIDTH(PW), .INSTR_WIDTH(IW), .RESET_PC(16'h0000), .HALT_OPCODE(HALT_OP))
    dut0 (.clk(clk), .reset(reset), .bus(bus0));
  fetch_unit #(.PC_WIDTH(PW), .INSTR_WIDTH(IW), .RESET_PC(16'hFFFE), .HALT_OPCODE(HALT_OP))
    dut1 (.clk(clk), .reset(reset), .bus(bus1));

  logic [IW-1:0] rom0 [0:65535];
  logic [IW-1:0] rom1 [0:65535];

  // Synchronous ROMs, 1-cycle read latency
  always @(posedge clk) begin
    if (bus0.imem_rd_en) bus0.imem_rdata <= rom0[bus0.imem_addr];
    if (bus1.imem_rd_en) bus1.imem_rdata <= rom1[bus1.imem_addr];
  end

  typedef struct packed {
    logic          valid;
    logic [15:0]   pc;
    logic [IW-1:0] instr;
    logic          halted;
    logic [15:0]   count;
    logic          rd_en;
    logic          chk_addr;
    logic [15:0]   addr;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  // Reference model: the word currently handed to decode and the running tally
  logic        m_valid;
  logic [15:0] m_pc;
  logic        m_halted;
  int          m_count;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    m_valid  = 1'b0;
    m_pc     = 16'h0000;
    m_halted = 1'b0;
    m_count  = 0;
  endtask

  // One cycle: drive inputs, queue the expected view, then advance the model across the edge
  task automatic step(input logic st, input logic br, input logic [15:0] tgt);
    exp_t e;
    bus0.stall          = st;
    bus0.branch_taken   = br;
    bus0.branch_address = tgt;
    e.valid    = m_valid;
    e.pc       = m_pc;
    e.instr    = m_valid ? rom0[m_pc] : 20'h00000;
    e.halted   = m_halted;
    e.count    = m_count[15:0];
    e.rd_en    = !m_halted;
    e.chk_addr = !m_halted;
    if (br && m_valid)      e.addr = tgt;
    else if (st && m_valid) e.addr = m_pc;
    else if (m_valid)       e.addr = m_pc + 16'd1;
    else                    e.addr = 16'h0000;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (!m_halted) begin
      if (!m_valid) begin
        m_valid = 1'b1;
        m_pc    = 16'h0000;
      end else begin
        if (!st && m_count < 65535) m_count++;
        if (br)                                    m_pc = tgt;
        else if (st)                               m_pc = m_pc;
        else if (rom0[m_pc][19:15] == HALT_OP) begin
          m_valid  = 1'b0;
          m_halted = 1'b1;
        end else                                   m_pc = m_pc + 16'd1;
      end
    end
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    bus0.stall = 1'b0;
    bus0.branch_taken = 1'b0;
    #1;
    chk("rst_valid", {31'd0, bus0.fetch_valid}, 32'd0);
    chk("rst_instr", {12'd0, bus0.instruction_fetch}, 32'd0);
    chk("rst_pc",    {16'd0, bus0.pc_mux_output}, 32'd0);
    chk("rst_halted",{31'd0, bus0.halted}, 32'd0);
    chk("rst_count", {16'd0, bus0.fetch_count}, 32'd0);
    repeat (cycles) @(posedge clk);
    #1;
    reset = 1'b0;
    sb.delete();
    model_reset();
  endtask

  // Monitor: pop one expected view per cycle and compare
  always @(negedge clk) begin
    if (!reset && sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk("fetch_valid", {31'd0, bus0.fetch_valid}, {31'd0, mon_e.valid});
      chk("pc_mux_output", {16'd0, bus0.pc_mux_output}, {16'd0, mon_e.pc});
      chk("instruction_fetch", {12'd0, bus0.instruction_fetch}, {12'd0, mon_e.instr});
      chk("halted", {31'd0, bus0.halted}, {31'd0, mon_e.halted});
      chk("fetch_count", {16'd0, bus0.fetch_count}, {16'd0, mon_e.count});
      chk("imem_rd_en", {31'd0, bus0.imem_rd_en}, {31'd0, mon_e.rd_en});
      if (mon_e.chk_addr) chk("imem_addr", {16'd0, bus0.imem_addr}, {16'd0, mon_e.addr});
    end
  end

  // Wrap instance: PCs FFFE, FFFF, 0000, 0001 after the first reset release
  initial begin
    logic [15:0] wp;
    bus1.stall = 1'b0;
    bus1.branch_taken = 1'b0;
    bus1.branch_address = 16'h0000;
    @(negedge reset);
    @(negedge clk);
    chk("wrap_boot_valid", {31'd0, bus1.fetch_valid}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      wp = 16'hFFFE + k[15:0];
      chk("wrap_valid", {31'd0, bus1.fetch_valid}, 32'd1);
      chk("wrap_pc", {16'd0, bus1.pc_mux_output}, {16'd0, wp});
      chk("wrap_instr", {12'd0, bus1.instruction_fetch}, {12'd0, rom1[wp]});
    end
  end

  initial begin
    int stall_n;
    logic br_done;
    logic st, br;
    logic [15:0] tgt;
    logic [IW-1:0] w;
    for (int i = 0; i < 65536; i++) begin
      rom0[i] = {4'h0, i[15:0]};
      rom1[i] = {4'h0, i[15:0]};
    end
    bus0.stall = 1'b0;
    bus0.branch_taken = 1'b0;
    bus0.branch_address = 16'h0000;
    model_reset();
    @(posedge clk);
    do_reset(2);

    // Directed: stall 3 cycles at pc 5, branch+stall to 0x40 at pc 9
    stall_n = 0;
    br_done = 1'b0;
    for (int i = 0; i < 24; i++) begin
      st = 1'b0;
      br = 1'b0;
      if (m_valid && m_pc == 16'd5 && stall_n < 3) begin
        st = 1'b1;
        stall_n++;
      end
      if (m_valid && m_pc == 16'd9 && !br_done) begin
        st = 1'b1;
        br = 1'b1;
        br_done = 1'b1;
      end
      step(st, br, 16'h0040);
    end

    // Random stall/branch traffic, targets biased toward the wrap boundary sometimes
    for (int i = 0; i < 400; i++) begin
      st  = ($urandom_range(0, 3) == 0);
      br  = ($urandom_range(0, 9) == 0) && m_valid;
      tgt = ($urandom_range(0, 3) == 0) ? (16'hFFF8 + 16'($urandom_range(0, 7))) : 16'($urandom);
      step(st, br, tgt);
    end

    // Reset asserted asynchronously while stalled at pc 7
    do_reset(2);
    for (int i = 0; i < 20; i++) begin
      if (!(m_valid && m_pc == 16'd7)) step(1'b0, 1'b0, 16'h0000);
    end
    chk("midstall_reached_pc7", {16'd0, m_pc}, 32'd7);
    step(1'b1, 1'b0, 16'h0000);
    bus0.stall = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_valid", {31'd0, bus0.fetch_valid}, 32'd0);
    chk("midrst_count", {16'd0, bus0.fetch_count}, 32'd0);
    chk("midrst_pc", {16'd0, bus0.pc_mux_output}, 32'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    bus0.stall = 1'b0;
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 16'h0000);

    // HALT word at address 3, then branch pulses that must be ignored
    rom0[3] = {5'b11111, 15'h0000};
    do_reset(2);
    for (int i = 0; i < 16; i++) begin
      br = m_halted && ($urandom_range(0, 1) == 1);
      step(1'b0, br, 16'h0020);
    end
    chk("halt_reached", {31'd0, m_halted}, 32'd1);

    // Random ROM contents with occasional HALT words
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 65536; i++) begin
        w = 20'($urandom);
        if (w[19:15] == HALT_OP) w[15] = 1'b0;
        if ($urandom_range(0, 31) == 0) w[19:15] = HALT_OP;
        rom0[i] = w;
      end
      do_reset(1 + r);
      for (int i = 0; i < 150; i++) begin
        st  = ($urandom_range(0, 3) == 0);
        br  = ($urandom_range(0, 7) == 0) && m_valid;
        tgt = 16'($urandom);
        step(st, br, tgt);
      end
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch front end: produces `instruction_fetch` and `pc_mux_output` for FetchDecode_register.
- Drives a synchronous instruction ROM with 1-cycle read latency.
- Sequences the PC, holds on load-use stall, redirects on taken branch from decode, and stops on HALT.
- Replaces the hand-driven fetch stimulus in the CPU benches.

Parameters:
- PC_WIDTH, 16, width of PC and ROM address.
- INSTR_WIDTH, 20, instruction word width.
- RESET_PC, 16'h0000, first fetched address after reset.
- HALT_OPCODE, 5'b11111, opcode (bits [19:15]) that stops fetch.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  hazard-unit hold request (load-use); fetch output must stay frozen.
- branch_taken  in  1  comparator_branch select_pc_mux; decode-stage branch is taken.
- branch_address  in  PC_WIDTH  branch target from substractor_branch.
- imem_addr  out  PC_WIDTH  ROM read address (combinational, see Behaviour).
- imem_rd_en  out  1  ROM read enable.
- imem_rdata  in  INSTR_WIDTH  ROM data for the address presented on the previous cycle.
- instruction_fetch  out  INSTR_WIDTH  instruction to FetchDecode_register; 0 (NOP) when not valid.
- pc_mux_output  out  PC_WIDTH  PC of instruction_fetch.
- fetch_valid  out  1  instruction_fetch holds a real instruction.
- halted  out  1  fetch stopped by HALT.
- fetch_count  out  16  count of instructions handed to decode, saturating.

Behaviour:
- Registers:
  - issue_pc: next address to read.
  - out_pc: address whose data is on imem_rdata.
  - out_valid.
  - state ∈ {BOOT, RUN, HALTED}.
  - fetch_count.
- Reset (async, any cycle, including mid-stall or mid-redirect):
  - state=BOOT, issue_pc=RESET_PC, out_pc=RESET_PC, out_valid=0, fetch_count=0.
  - Outputs during reset: fetch_valid=0, instruction_fetch=0, pc_mux_output=RESET_PC, halted=0.
- imem_addr mux (combinational), in priority order:
  - branch_taken → branch_address.
  - else stall and out_valid → out_pc (re-read the held instruction so data stays stable).
  - else issue_pc.
- imem_rd_en = 1 in BOOT/RUN, 0 in HALTED.
- instruction_fetch = out_valid ? imem_rdata : 0. pc_mux_output = out_pc. fetch_valid = out_valid.
- BOOT:
  - One cycle. ROM reads RESET_PC.
  - Next: out_pc=RESET_PC, issue_pc=RESET_PC+1, out_valid=1, state=RUN.
  - Fetch latency from reset deassert to first valid instruction is 1 clock edge.
- RUN, each edge, in priority order:
  - branch_taken: out_pc←branch_address, issue_pc←branch_address+1, out_valid←1. Overrides stall and HALT detection; the current fetch-stage word is wrong-path. Flushing FetchDecode_register is the hazard unit's job, not this block's.
  - stall: out_pc, issue_pc, out_valid held. Zero-bubble resume: after stall drops, the next edge advances exactly as normal.
  - out_valid and imem_rdata[19:15]==HALT_OPCODE: the HALT word is presented this cycle with fetch_valid=1. Next edge: state=HALTED, out_valid←0.
  - otherwise: out_pc←issue_pc, issue_pc←issue_pc+1, out_valid←1.
- HALTED:
  - fetch_valid=0, halted=1, imem_rd_en=0. branch_taken and stall are ignored.
  - Only reset exits.
- PC arithmetic: modulo 2^PC_WIDTH; 16'hFFFF+1 = 16'h0000, no flag. branch_address+1 wraps the same way.
- fetch_count:
  - +1 on each edge where fetch_valid=1 and stall=0 (instruction accepted by decode).
  - Counts the HALT word and wrong-path words that are later flushed.
  - Saturates at 16'hFFFF.
- Simultaneous branch_taken and stall: branch wins. The redirect target appears next cycle.

Test Plan:
- ROM[i]=20'h0_0000+i; reset 2 cycles then release → first valid: pc_mux_output=0, instruction_fetch=ROM[0] one edge after release; then PCs 1,2,3 on consecutive edges; fetch_count=3 after pc 3 appears.
- Stall for 3 cycles while pc_mux_output=5 → instruction_fetch=ROM[5] and pc 5 held all 3 cycles, imem_addr=5 during stall, fetch_count frozen; pc 6 on the edge after stall drops.
- branch_taken=1 with branch_address=16'h0040 while fetching pc 9, stall=1 same cycle → next edge pc_mux_output=16'h0040, ROM[0x40] valid; following edge pc 16'h0041.
- ROM[3]=20'b11111_000000000000000 → pc 3 presented with fetch_valid=1; next edge halted=1, fetch_valid=0, imem_rd_en=0; branch_taken pulses afterwards have no effect.
- RESET_PC=16'hFFFE → PCs FFFE, FFFF, 0000, 0001 in order, no stall or glitch.
- Assert reset mid-stall at pc 7 → outputs clear immediately (fetch_valid=0, fetch_count=0); after release fetch restarts at RESET_PC.
